accel_layer_sched: RTL and testbench

Layer sequencer for the conv/activation/pool accelerator. On a start pulse it loads the k*k weight set from a weight memory and streams one MAP_SIZE x MAP_SIZE activation map from an activation memory, driving activation/ce. It flushes the pipeline and writes every pooled result (data_out/valid_op) into an output memory. It reports busy, done and error status to the host.

---
 rtl/accel_layer_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_accel_layer_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_layer_sched.sv
// rtl/accel_layer_sched.sv - layer sequencer: weight load, activation stream, pipeline drain, result capture
module accel_layer_sched #(
  parameter int MAP_SIZE  = 10,
  parameter int k         = 3,
  parameter int p         = 2,
  parameter int N         = 8,
  parameter int A_AW      = 7,
  parameter int W_AW      = 4,
  parameter int O_AW      = 5,
  parameter int DRAIN_MAX = 64
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               w_rd_en,
  output logic [W_AW-1:0]    w_addr,
  input  logic [N-1:0]       w_rd_data,
  output logic [k*k*N-1:0]   weight1,
  output logic               a_rd_en,
  output logic [A_AW-1:0]    a_addr,
  input  logic [N-1:0]       a_rd_data,
  output logic [N-1:0]       activation,
  output logic               ce,
  input  logic [N-1:0]       data_out,
  input  logic               valid_op,
  input  logic               end_op,
  output logic               o_wr_en,
  output logic [O_AW-1:0]    o_addr,
  output logic [N-1:0]       o_wr_data,
  output logic [O_AW:0]      out_count
);

  localparam int KK       = k * k;
  localparam int NPIX     = MAP_SIZE * MAP_SIZE;
  localparam int OUT_SIDE = (MAP_SIZE - k + 1) / p;
  localparam int OUT_CNT  = OUT_SIDE * OUT_SIDE;
  localparam int DW       = $clog2(DRAIN_MAX) + 1;

  localparam logic [W_AW-1:0] W_LAST    = W_AW'(KK - 1);
  localparam logic [A_AW:0]   NPIX_V    = (A_AW + 1)'(NPIX);
  localparam logic [O_AW:0]   OUT_CNT_V = (O_AW + 1)'(OUT_CNT);
  localparam logic [DW-1:0]   D_LAST    = DW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_w_rd_en;
  logic [W_AW-1:0]    r_w_addr;
  logic               r_cap_en;
  logic [W_AW-1:0]    r_cap_idx;
  logic [k*k*N-1:0]   r_weight1;
  logic [A_AW:0]      r_rd_idx;
  logic               r_rd_pend;
  logic [A_AW:0]      r_pres_cnt;
  logic [N-1:0]       r_activation;
  logic               r_ce;
  logic [DW-1:0]      r_drain_cnt;
  logic               r_o_wr_en;
  logic [O_AW-1:0]    r_o_addr;
  logic [N-1:0]       r_o_wr_data;
  logic [O_AW:0]      r_out_cnt;

  logic w_start_ok;
  logic w_act_issue;
  logic w_capture;
  logic w_drain_exit;

  // A start is only honoured when no layer is in flight.
  assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  // Activation reads are issued combinationally so hold takes effect in the same cycle.
  assign w_act_issue  = (r_state == S_STREAM) && !hold && (r_rd_idx < NPIX_V);
  assign w_capture    = (r_state == S_STREAM || r_state == S_DRAIN) && valid_op && (r_out_cnt < OUT_CNT_V);
  assign w_drain_exit = (r_out_cnt == OUT_CNT_V) || (end_op && r_out_cnt != '0);

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign w_rd_en    = r_w_rd_en;
  assign w_addr     = r_w_addr;
  assign weight1    = r_weight1;
  assign a_rd_en    = w_act_issue;
  assign a_addr     = r_rd_idx[A_AW-1:0];
  assign activation = r_activation;
  assign ce         = r_ce;
  assign o_wr_en    = r_o_wr_en;
  assign o_addr     = r_o_addr;
  assign o_wr_data  = r_o_wr_data;
  assign out_count  = r_out_cnt;

  // Layer sequencing FSM: weight fetch, activation streaming with a one-cycle read pipeline, drain and status.
  always_ff @(posedge clk) begin
    if (!global_rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_w_rd_en    <= 1'b0;
      r_w_addr     <= '0;
      r_cap_en     <= 1'b0;
      r_cap_idx    <= '0;
      r_weight1    <= '0;
      r_rd_idx     <= '0;
      r_rd_pend    <= 1'b0;
      r_pres_cnt   <= '0;
      r_activation <= '0;
      r_ce         <= 1'b0;
      r_drain_cnt  <= '0;
    end else begin
      r_done    <= 1'b0;
      // Weight words return one cycle after the read; remember which slot they belong to.
      r_cap_en  <= r_w_rd_en;
      r_cap_idx <= r_w_addr;
      if (r_cap_en) begin
        r_weight1[int'(r_cap_idx) * N +: N] <= w_rd_data;
      end
      r_rd_pend <= w_act_issue;
      if (w_act_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start_ok) begin
            r_state    <= S_LOAD_W;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_weight1  <= '0;
            r_w_rd_en  <= 1'b1;
            r_w_addr   <= '0;
            r_rd_idx   <= '0;
            r_pres_cnt <= '0;
          end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
          end
        end

        S_LOAD_W: begin
          if (r_w_rd_en) begin
            if (r_w_addr == W_LAST) begin
              r_w_rd_en <= 1'b0;
              r_w_addr  <= '0;
            end else begin
              r_w_addr <= r_w_addr + 1'b1;
            end
          end
          if (r_cap_en && r_cap_idx == W_LAST) begin
            r_state <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (r_rd_pend) begin
            r_activation <= a_rd_data;
            r_ce         <= 1'b1;
            r_pres_cnt   <= r_pres_cnt + 1'b1;
          end else if (r_pres_cnt == NPIX_V) begin
            // Last activation has been presented; start feeding zeros to flush the pipeline.
            r_state      <= S_DRAIN;
            r_ce         <= 1'b1;
            r_activation <= '0;
            r_drain_cnt  <= '0;
          end else begin
            r_ce <= 1'b0;
          end
        end

        S_DRAIN: begin
          r_activation <= '0;
          if (w_drain_exit) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ce    <= 1'b0;
          end else if (r_drain_cnt == D_LAST) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_ce    <= 1'b0;
          end else begin
            r_ce        <= 1'b1;
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pooled-result capture into the output memory, capped at the expected result count.
  always_ff @(posedge clk) begin
    if (!global_rst) begin
      r_o_wr_en   <= 1'b0;
      r_o_addr    <= '0;
      r_o_wr_data <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_o_wr_en <= 1'b0;
      if (w_start_ok) begin
        r_out_cnt <= '0;
      end else if (w_capture) begin
        r_o_wr_en   <= 1'b1;
        r_o_addr    <= r_out_cnt[O_AW-1:0];
        r_o_wr_data <= data_out;
        r_out_cnt   <= r_out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_layer_sched.sv
// tb/tb_accel_layer_sched.sv - directed self-checking bench for accel_layer_sched
module tb_accel_layer_sched;

  localparam int NPIX = 100;

  logic        clk = 1'b0;
  logic        global_rst;
  logic        start;
  logic        hold;
  logic        busy;
  logic        done;
  logic        error;
  logic        w_rd_en;
  logic [3:0]  w_addr;
  logic [7:0]  w_rd_data;
  logic [71:0] weight1;
  logic        a_rd_en;
  logic [6:0]  a_addr;
  logic [7:0]  a_rd_data;
  logic [7:0]  activation;
  logic        ce;
  logic [7:0]  data_out;
  logic        valid_op;
  logic        end_op;
  logic        o_wr_en;
  logic [4:0]  o_addr;
  logic [7:0]  o_wr_data;
  logic [5:0]  out_count;

  always #5 clk = ~clk;

  accel_layer_sched dut (
    .clk        (clk),
    .global_rst (global_rst),
    .start      (start),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .w_rd_en    (w_rd_en),
    .w_addr     (w_addr),
    .w_rd_data  (w_rd_data),
    .weight1    (weight1),
    .a_rd_en    (a_rd_en),
    .a_addr     (a_addr),
    .a_rd_data  (a_rd_data),
    .activation (activation),
    .ce         (ce),
    .data_out   (data_out),
    .valid_op   (valid_op),
    .end_op     (end_op),
    .o_wr_en    (o_wr_en),
    .o_addr     (o_addr),
    .o_wr_data  (o_wr_data),
    .out_count  (out_count)
  );

  logic [7:0] wmem [16];
  logic [7:0] amem [128];
  logic [7:0] omem [32];

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) if (w_rd_en) w_rd_data <= wmem[w_addr];
  always @(posedge clk) if (a_rd_en) a_rd_data <= amem[a_addr];

  int checks = 0;
  int failures = 0;

  int cyc, wen_cnt, waddr_bad, first_rd, rd_exp, addr_bad, ce_cnt, act_bad;
  int gap, emitted, wr_cnt, done_cnt, busy_bad;
  logic        e1;
  logic [5:0]  oc1;
  logic [71:0] w1;
  logic [71:0] wexp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int omem_bad(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (omem[i] !== 8'(16 + i)) bad++;
    return bad;
  endfunction

  // Issue a start and run cycle by cycle, acting as accelerator model and monitor.
  // Results are emitted on the ce-cycle numbers vstart, vstart+vgap, ...
  task automatic run_layer(input int vstart, input int vgap, input int vnum,
                           input int hold_at, input int hold_len, input int rst_at,
                           input int max_cyc);
    int hold_left = 0;
    bit hold_used = 0;
    bit ended = 0;
    cyc = 0; wen_cnt = 0; waddr_bad = 0; first_rd = -1; rd_exp = 0; addr_bad = 0;
    ce_cnt = 0; act_bad = 0; gap = 0; emitted = 0; wr_cnt = 0; done_cnt = 0; busy_bad = 0;
    for (int i = 0; i < 32; i++) omem[i] = 8'hEE;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (hold_left > 0) begin
        hold = 1'b1;
        hold_left--;
      end else if (!hold_used && hold_len > 0 && rd_exp == hold_at) begin
        hold = 1'b1;
        hold_left = hold_len - 1;
        hold_used = 1'b1;
      end else begin
        hold = 1'b0;
      end
      valid_op = 1'b0;
      if (ce) begin
        ce_cnt++;
        if (ce_cnt <= NPIX) begin
          if (activation !== 8'(ce_cnt - 1)) act_bad++;
        end else if (activation !== 8'h00) begin
          act_bad++;
        end
        if (emitted < vnum && ce_cnt == vstart + emitted * vgap) begin
          valid_op = 1'b1;
          data_out = 8'(16 + emitted);
          emitted++;
        end
      end else if (ce_cnt > 0 && ce_cnt < NPIX) begin
        gap++;
      end
      #1;
      if (cyc == 1) begin
        e1 = error;
        oc1 = out_count;
        w1 = weight1;
      end
      if (w_rd_en) begin
        if (w_addr !== 4'(wen_cnt)) waddr_bad++;
        wen_cnt++;
      end
      if (a_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (a_addr !== 7'(rd_exp)) addr_bad++;
        rd_exp++;
      end
      if (o_wr_en) begin
        omem[o_addr] = o_wr_data;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
      end
      if (done || error || (rst_at >= 0 && rd_exp == rst_at)) begin
        ended = 1'b1;
        break;
      end
    end
    hold = 1'b0;
    valid_op = 1'b0;
    chk("layer_bound", ended, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idle_wr;
    global_rst = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    valid_op = 1'b0;
    end_op = 1'b0;
    data_out = 8'h00;
    for (int i = 0; i < 16; i++) wmem[i] = 8'(i + 1);
    for (int i = 0; i < 128; i++) amem[i] = 8'(i);
    for (int i = 0; i < 9; i++) wexp[i*8 +: 8] = 8'(i + 1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {busy, done, error, w_rd_en, a_rd_en, ce, o_wr_en}, 0);
    chk("rst_data", {w_addr, a_addr, activation, o_wr_data, out_count}, 0);
    chk("rst_weight", weight1, 0);
    global_rst = 1'b1;

    // Full layer: weight load timing and 16 results spread over stream and drain.
    run_layer(50, 4, 16, -1, 0, -1, 400);
    chk("w_en_cycles", wen_cnt, 9);
    chk("w_addr_seq", waddr_bad, 0);
    chk("weight1", weight1, wexp);
    chk("stream_first_read_cyc", first_rd, 11);
    chk("act_seq", act_bad, 0);
    chk("a_addr_seq", addr_bad, 0);
    chk("reads_total", rd_exp, 100);
    chk("writes", wr_cnt, 16);
    chk("omem", omem_bad(16), 0);
    chk("out_count", out_count, 16);
    chk("done_pulses", done_cnt, 1);
    chk("busy_at_done", busy_bad, 0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);

    // Hold for 5 cycles at read index 40.
    run_layer(50, 4, 16, 40, 5, -1, 400);
    chk("hold_ce_gap", gap, 5);
    chk("hold_act_seq", act_bad, 0);
    chk("hold_a_addr_seq", addr_bad, 0);
    chk("hold_reads", rd_exp, 100);
    chk("hold_writes", wr_cnt, 16);
    chk("hold_done", done_cnt, 1);

    // 20 back-to-back results: only the first 16 are written.
    run_layer(105, 1, 20, -1, 0, -1, 400);
    chk("ovf_emitted_extra", emitted > 16, 1);
    chk("ovf_writes", wr_cnt, 16);
    chk("ovf_out_count", out_count, 16);
    chk("ovf_omem", omem_bad(16), 0);
    idle_wr = 0;
    @(negedge clk);
    valid_op = 1'b1;
    data_out = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (o_wr_en) idle_wr++;
    end
    valid_op = 1'b0;
    chk("idle_valid_dropped", idle_wr, 0);
    chk("idle_out_count", out_count, 16);

    // Only 10 results and no end_op: drain times out after 64 cycles.
    run_layer(50, 4, 10, -1, 0, -1, 400);
    chk("to_error", error, 1);
    chk("to_ce", ce, 0);
    chk("to_busy", busy, 0);
    chk("to_no_done", done_cnt, 0);
    chk("to_ce_total", ce_cnt, 164);
    chk("to_out_count", out_count, 10);
    repeat (2) @(negedge clk);
    #1;
    chk("to_error_sticky", error, 1);

    // Next start clears the error and runs a clean layer.
    run_layer(50, 4, 16, -1, 0, -1, 400);
    chk("restart_err_clr", e1, 0);
    chk("restart_cnt_clr", oc1, 0);
    chk("restart_w_clr", w1, 0);
    chk("restart_done", done_cnt, 1);
    chk("restart_error", error, 0);
    chk("restart_writes", wr_cnt, 16);

    // Reset in the middle of streaming.
    run_layer(50, 4, 16, -1, 0, 50, 400);
    chk("mid_reads", rd_exp, 50);
    global_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_ctrl", {busy, done, error, w_rd_en, a_rd_en, ce, o_wr_en}, 0);
    chk("mid_rst_data", {w_addr, a_addr, activation, o_wr_data, out_count}, 0);
    chk("mid_rst_weight", weight1, 0);
    global_rst = 1'b1;
    run_layer(50, 4, 16, -1, 0, -1, 400);
    chk("post_first_read_cyc", first_rd, 11);
    chk("post_a_addr_seq", addr_bad, 0);
    chk("post_reads", rd_exp, 100);
    chk("post_act_seq", act_bad, 0);
    chk("post_omem", omem_bad(16), 0);
    chk("post_done", done_cnt, 1);
    chk("post_weight1", weight1, wexp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
